// File: rtl/axis_stream_arbiter_pkg.sv
// Shared constants and helpers for the packet-granular AXI-Stream arbiter.
package axis_stream_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PASS = 1'b1;

    // Smallest r with 2**r >= n; used to validate the grant index width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_stream_arbiter_if.sv
// Bundles the N requester streams and the single arbitrated output stream.
interface axis_stream_arbiter_if #(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned AXIS_DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]                 i_axis_in_tuser;
    logic [NUM_PORTS-1:0]                 i_axis_in_tvalid;
    logic [NUM_PORTS-1:0]                 o_axis_in_tready;
    logic [NUM_PORTS-1:0]                 i_axis_in_tlast;
    logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] i_axis_in_tdata;
    logic                                 o_axis_out_tuser;
    logic                                 o_axis_out_tvalid;
    logic                                 i_axis_out_tready;
    logic                                 o_axis_out_tlast;
    logic [AXIS_DATA_WIDTH-1:0]           o_axis_out_tdata;

    // Arbiter side
    modport slave (
        input  i_axis_in_tuser, i_axis_in_tvalid, i_axis_in_tlast, i_axis_in_tdata,
        input  i_axis_out_tready,
        output o_axis_in_tready,
        output o_axis_out_tuser, o_axis_out_tvalid, o_axis_out_tlast, o_axis_out_tdata
    );

    // Requesters plus downstream consumer
    modport master (
        output i_axis_in_tuser, i_axis_in_tvalid, i_axis_in_tlast, i_axis_in_tdata,
        output i_axis_out_tready,
        input  o_axis_in_tready,
        input  o_axis_out_tuser, o_axis_out_tvalid, o_axis_out_tlast, o_axis_out_tdata
    );
endinterface

// File: rtl/axis_stream_arbiter_rr_priority_select.sv
// Round-robin pick: first set request strictly after last_grant, wrapping.
module rr_priority_select #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned ID_WIDTH  = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [ID_WIDTH-1:0]  last_grant_i,
    output logic                 found_o,
    output logic [ID_WIDTH-1:0]  next_id_o
);

    logic [2*NUM_PORTS-1:0] dbl_c;
    logic [NUM_PORTS-1:0]   rot_c;
    int unsigned            start_c;
    logic                   hit_c;

    // Rotate so the highest-priority port lands at bit 0, then take the lowest set bit.
    always_comb begin
        start_c   = (32'(last_grant_i) + 32'd1) % NUM_PORTS;
        dbl_c     = {req_i, req_i};
        rot_c     = NUM_PORTS'(dbl_c >> start_c);
        found_o   = |req_i;
        next_id_o = '0;
        hit_c     = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (rot_c[i] && !hit_c) begin
                hit_c     = 1'b1;
                next_id_o = ID_WIDTH'((start_c + i) % NUM_PORTS);
            end
        end
    end

endmodule

// File: rtl/axis_stream_arbiter.sv
// Packet-granular round-robin arbiter: holds a grant from first beat to tlast.
module axis_stream_arbiter
    import axis_stream_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned AXIS_DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH        = 2,
    parameter int unsigned COUNT_WIDTH     = 32
) (
    input  logic                   i_axi_clk,
    input  logic                   i_axi_rst,
    input  logic [NUM_PORTS-1:0]   i_port_en,
    axis_stream_arbiter_if.slave   axis,
    output logic [ID_WIDTH-1:0]    o_grant_id,
    output logic                   o_busy,
    output logic [COUNT_WIDTH-1:0] o_pkt_count
);

    if (ID_WIDTH != clog2(NUM_PORTS)) begin : g_bad_id_width
        $error("ID_WIDTH must equal clog2(NUM_PORTS)");
    end

    logic [0:0]             state_q, state_d;
    logic [ID_WIDTH-1:0]    grant_q, grant_d;
    logic [ID_WIDTH-1:0]    last_q, last_d;
    logic                   busy_q, busy_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [NUM_PORTS-1:0]       req_c;
    logic                       found_c;
    logic [ID_WIDTH-1:0]        next_id_c;
    logic                       sel_valid_c, sel_last_c, sel_user_c;
    logic [AXIS_DATA_WIDTH-1:0] sel_data_c;
    logic [NUM_PORTS-1:0]       in_ready_c;
    logic                       out_valid_c, out_last_c, out_user_c;
    logic [AXIS_DATA_WIDTH-1:0] out_data_c;

    assign req_c = axis.i_axis_in_tvalid & i_port_en;

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .ID_WIDTH  (ID_WIDTH)
    ) u_rr_sel (
        .req_i        (req_c),
        .last_grant_i (last_q),
        .found_o      (found_c),
        .next_id_o    (next_id_c)
    );

    // Grant mux; out-of-range grant codes select nothing.
    always_comb begin
        sel_valid_c = 1'b0;
        sel_last_c  = 1'b0;
        sel_user_c  = 1'b0;
        sel_data_c  = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (grant_q == ID_WIDTH'(k)) begin
                sel_valid_c = axis.i_axis_in_tvalid[k];
                sel_last_c  = axis.i_axis_in_tlast[k];
                sel_user_c  = axis.i_axis_in_tuser[k];
                sel_data_c  = axis.i_axis_in_tdata[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        out_user_c  = 1'b0;
        out_data_c  = '0;
        in_ready_c  = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    grant_d = next_id_c;
                    busy_d  = 1'b1;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                out_valid_c = sel_valid_c;
                out_last_c  = sel_last_c;
                out_user_c  = sel_user_c;
                out_data_c  = sel_data_c;
                for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                    in_ready_c[k] = (grant_q == ID_WIDTH'(k)) && axis.i_axis_out_tready;
                end
                if (sel_valid_c && axis.i_axis_out_tready && sel_last_c) begin
                    last_d  = grant_q;
                    cnt_d   = cnt_q + COUNT_WIDTH'(1);
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= ID_WIDTH'(NUM_PORTS - 1);
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data path is a zero-latency pass-through while a packet is granted.
    assign axis.o_axis_in_tready  = in_ready_c;
    assign axis.o_axis_out_tvalid = out_valid_c;
    assign axis.o_axis_out_tlast  = out_last_c;
    assign axis.o_axis_out_tuser  = out_user_c;
    assign axis.o_axis_out_tdata  = out_data_c;
    assign o_grant_id             = grant_q;
    assign o_busy                 = busy_q;
    assign o_pkt_count            = cnt_q;

endmodule
